// File: rtl/aes_wddl_pkg.sv
// Shared types and constants for the dual-rail (WDDL) MixColumns sequencer.
// Column helper returns column c of a 128-bit state, column 0 in the MSBs.
package aes_wddl_pkg;

    localparam int AES_COL_W = 32;
    localparam int AES_ST_W  = 128;
    localparam logic [AES_COL_W-1:0] WDDL_PRECHARGE = 32'h0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PRE  = 2'd1,
        EVAL = 2'd2,
        DONE = 2'd3
    } seq_state_e;

    function automatic logic [AES_COL_W-1:0] col_of(input logic [AES_ST_W-1:0] s,
                                                    input logic [1:0]          c);
        case (c)
            2'd0:    col_of = s[127:96];
            2'd1:    col_of = s[95:64];
            2'd2:    col_of = s[63:32];
            default: col_of = s[31:0];
        endcase
    endfunction

endpackage

// File: rtl/aes_mixcolumns_wddl.sv
// Combinational dual-rail MixColumns column datapath: each rail is mixed independently.
// MixColumns is linear and maps all-ones to all-ones, so mix(~x) == ~mix(x) and 0/0 stays 0/0.
module aes_mixcolumns_wddl
    import aes_wddl_pkg::*;
(
    input  logic [AES_COL_W-1:0] col_p,
    input  logic [AES_COL_W-1:0] col_n,
    output logic [AES_COL_W-1:0] mc_p,
    output logic [AES_COL_W-1:0] mc_n
);

    function automatic logic [7:0] xt(input logic [7:0] x);
        xt = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mix(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        a0 = c[31:24];
        a1 = c[23:16];
        a2 = c[15:8];
        a3 = c[7:0];
        mix = {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
               a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
               a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
               xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
    endfunction

    assign mc_p = mix(col_p);
    assign mc_n = mix(col_n);

endmodule

// File: rtl/aes_wddl_phase_ctr.sv
// Loadable down-counter timing the precharge and evaluate phases.
// tc is high while the count sits at zero; the counter only moves again on a reload.
module aes_wddl_phase_ctr #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         tc
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc = (cnt_q == '0);

endmodule

// File: rtl/aes_mixcol_seq_wddl.sv
// Shares one dual-rail MixColumns column datapath across four columns, with precharge before each evaluate.
// Optional rail-fault checker enabled by defining WDDL_RAIL_CHECK_EN.
module aes_mixcol_seq_wddl
    import aes_wddl_pkg::*;
#(
    parameter int PRE_CYCLES  = 1,
    parameter int EVAL_CYCLES = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [AES_ST_W-1:0]  st_p,
    input  logic [AES_ST_W-1:0]  st_n,
    output logic [AES_COL_W-1:0] col_p,
    output logic [AES_COL_W-1:0] col_n,
    output logic                 prech,
    input  logic [AES_COL_W-1:0] mc_p,
    input  logic [AES_COL_W-1:0] mc_n,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [AES_ST_W-1:0]  mix_p,
    output logic [AES_ST_W-1:0]  mix_n,
    output logic                 rail_err
);

    localparam int MAX_CYC = (PRE_CYCLES > EVAL_CYCLES) ? PRE_CYCLES : EVAL_CYCLES;
    localparam int CTR_W   = $clog2(MAX_CYC) + 1;
    localparam logic [CTR_W-1:0] PRE_LOAD  = CTR_W'(PRE_CYCLES - 1);
    localparam logic [CTR_W-1:0] EVAL_LOAD = CTR_W'(EVAL_CYCLES - 1);

    seq_state_e            state_q, state_d;
    logic [1:0]            idx_q, idx_d;
    logic [AES_ST_W-1:0]   st_p_q, st_n_q;
    logic [AES_COL_W-1:0]  col_p_q, col_n_q;
    logic                  prech_q;

    logic                  ctr_load;
    logic [CTR_W-1:0]      ctr_val;
    logic                  tc;
    logic                  accept;
    logic                  col_load;
    logic                  col_clr;
    logic                  capture;

    aes_wddl_phase_ctr #(
        .W(CTR_W)
    ) u_phase_ctr (
        .clk      (clk),
        .rst      (rst),
        .load     (ctr_load),
        .load_val (ctr_val),
        .tc       (tc)
    );

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        ctr_load = 1'b0;
        ctr_val  = '0;
        accept   = 1'b0;
        col_load = 1'b0;
        col_clr  = 1'b0;
        capture  = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    accept   = 1'b1;
                    idx_d    = 2'd0;
                    ctr_load = 1'b1;
                    ctr_val  = PRE_LOAD;
                    state_d  = PRE;
                end
            end
            PRE: begin
                if (tc) begin
                    col_load = 1'b1;
                    ctr_load = 1'b1;
                    ctr_val  = EVAL_LOAD;
                    state_d  = EVAL;
                end
            end
            EVAL: begin
                if (tc) begin
                    capture = 1'b1;
                    col_clr = 1'b1;
                    if (idx_q == 2'd3) begin
                        state_d = DONE;
                    end else begin
                        idx_d    = idx_q + 2'd1;
                        ctr_load = 1'b1;
                        ctr_val  = PRE_LOAD;
                        state_d  = PRE;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= 2'd0;
            st_p_q  <= '0;
            st_n_q  <= '0;
            col_p_q <= WDDL_PRECHARGE;
            col_n_q <= WDDL_PRECHARGE;
            prech_q <= 1'b1;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            if (accept) begin
                st_p_q <= st_p;
                st_n_q <= st_n;
            end
            // Column drive is registered so both rails leave 0/0 on the same edge.
            if (col_load) begin
                col_p_q <= col_of(st_p_q, idx_q);
                col_n_q <= col_of(st_n_q, idx_q);
                prech_q <= 1'b0;
            end else if (col_clr) begin
                col_p_q <= WDDL_PRECHARGE;
                col_n_q <= WDDL_PRECHARGE;
                prech_q <= 1'b1;
            end
        end
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_slot
        logic [AES_COL_W-1:0] slot_p_q, slot_n_q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                slot_p_q <= '0;
                slot_n_q <= '0;
            end else if (capture && (idx_q == 2'(gi))) begin
                slot_p_q <= mc_p;
                slot_n_q <= mc_n;
            end
        end

        assign mix_p[AES_ST_W-1-AES_COL_W*gi -: AES_COL_W] = slot_p_q;
        assign mix_n[AES_ST_W-1-AES_COL_W*gi -: AES_COL_W] = slot_n_q;
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign col_p     = col_p_q;
    assign col_n     = col_n_q;
    assign prech     = prech_q;

`ifdef WDDL_RAIL_CHECK_EN
    logic rail_err_q;

    // A healthy pair is complementary when captured and fully discharged at the end of precharge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rail_err_q <= 1'b0;
        end else if ((capture && ((mc_p ^ mc_n) != 32'hFFFF_FFFF)) ||
                     ((state_q == PRE) && tc && ((mc_p | mc_n) != '0))) begin
            rail_err_q <= 1'b1;
        end
    end

    assign rail_err = rail_err_q;
`else
    assign rail_err = 1'b0;
`endif

endmodule
